info_frame_engine: RTL and testbench
====================================

# info_frame_engine

Runtime-programmable HDMI InfoFrame packet engine: it replaces the fixed-parameter InfoFrame generators with one block that serves any InfoFrame type (AVI, SPD, Audio, Vendor). Software or control logic writes header fields and payload bytes PB1..PB27 into a staging buffer, then commits. The engine computes the checksum byte PB0 sequentially and swaps the result atomically into the active packet registers. The active registers drive the packet assembler's `header`/`sub` inputs in the pixel-clock domain.

## Interface
Parameters:
- `MAX_LENGTH`, 27: largest payload byte count accepted; legal range 1..27.
- `HEADER_BIT7`, 1'b1: value of header byte 0 bit 7, the InfoFrame type-code MSB.

Ports:
- `clk_pixel` in 1: the block's single clock.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: staging byte write strobe.
- `wr_addr` in 5: payload byte index. Valid range is 1..`MAX_LENGTH`; index 0 and out-of-range indices are ignored.
- `wr_data` in 8: payload byte value.
- `hdr_type` in 7: InfoFrame type code, sampled at commit.
- `hdr_version` in 8: version byte, sampled at commit.
- `hdr_length` in 5: payload length, sampled at commit and clamped to `MAX_LENGTH`.
- `commit` in 1: one-cycle pulse that starts checksum and update.
- `swap` in 1: frame-boundary strobe, e.g. start of vsync.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `valid` out 1: active registers hold a committed packet.
- `header` out 24: {3'b0, length}, version, {HEADER_BIT7, type}.
- `sub` out 56 x [3:0]: sub[i] = {PB(6+7i) .. PB(7i)}, with PB0 in the low byte.

## Operation
- Staging buffer holds PB1..PB27. `wr_en` writes it only in IDLE; writes are ignored while `busy`.
- The FSM has three states: IDLE, SUM, WAIT_SWAP.
- **IDLE:**
  - `commit` latches the header fields, with length clamped to `MAX_LENGTH`.
  - The 8-bit accumulator clears, and the FSM moves to SUM.
  - `swap` is ignored.
- **SUM:**
  - Adds one byte per cycle, modulo 256.
  - Order is header byte 0, header byte 1, header byte 2, then PB1..PB(length).
  - Exactly length+3 cycles are spent here. A length of 0 gives 3 cycles.
  - The FSM then moves to WAIT_SWAP, and PB0 = (~acc)+1 is registered.
- **WAIT_SWAP:**
  - On `swap`, the active header, PB0 and PB1..PB27 are loaded.
  - Any byte with index > length is loaded as 0x00.
  - `valid` is set to 1 and the FSM returns to IDLE.
- `commit` outside IDLE is ignored; no queuing.
- A `wr_en` and `commit` arriving in the same IDLE cycle: the write lands and is included in the sum and the packet.
- The active registers change only on swap. Outputs stay stable for the whole time a new packet is being prepared.
- Reset:
  - `header`=0, all `sub`=0, `valid`=0, `busy`=0.
  - Staging buffer cleared and FSM to IDLE.
  - Reset mid-SUM or mid-WAIT_SWAP discards the pending packet.

## Timing
- Commit accepted in cycle T: `busy`=1 from T+1.
- SUM occupies T+1..T+L+3, where L is the clamped length. The FSM is in WAIT_SWAP at T+L+4.
- `swap` sampled in WAIT_SWAP at cycle S: new `header`/`sub`/`valid` visible at S+1, and `busy`=0 at S+1.
- `swap` coincident with the SUM→WAIT_SWAP transition cycle is not honoured. The first honoured swap is one sampled while already in WAIT_SWAP.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `INFO_FRAME_SYNC_SWAP_EN`:
  - **Defined:** behaviour as above; the update waits for `swap`.
  - **Undefined:**
    - The `swap` port is ignored.
    - WAIT_SWAP lasts exactly one cycle and loads unconditionally, so outputs update at T+L+5.
    - `busy`=0 from T+L+5.

## Test plan
- **Reset outputs:** after reset, with no commits, `header`=24'h000000, all `sub`=0, `valid`=0 and `busy`=0.
- **AVI frame:**
  - Stimulus: write PB4=0x04, then commit with type=2, version=2, length=13.
  - Result: `header`=24'h0D0282, `sub[0]`=56'h0000040000006B (PB0=0x6B), `sub[1..3]`=0.
- **Latency, macro undefined:**
  - Stimulus: commit at T with L=13.
  - Result: `busy` rises at T+1, outputs update and `busy` falls at T+18.
- **Latency, macro defined:**
  - Stimulus: same commit, `swap` at T+20.
  - Result: outputs still hold the old packet at T+20 and update at T+21.
  - Also check that a `swap` pulse issued in IDLE beforehand changes nothing.
- **Length clamp and zero fill:**
  - Stimulus: write PB20=0xAA, then commit with length=31.
  - Result: header length field is 27 and PB20=0xAA is present.
  - Follow-up: recommit with length=5. PB20 reads 0x00 and PB0 is recomputed over PB1..PB5 only.
- **Busy protection and reset mid-op:**
  - Stimulus: during SUM, `wr_en` to PB1 and a second `commit`.
  - Result: both are ignored, and the packet matches the pre-commit staging contents.
  - Follow-up: assert `reset` in WAIT_SWAP. `valid`=0 and `header`=0 on the next cycle, and a later `swap` has no effect.

Source files
------------

// File: rtl/info_frame_engine.sv
// info_frame_engine: runtime-programmable HDMI InfoFrame packet engine.
// Payload bytes are staged, a commit sums header + payload one byte per
// cycle to form checksum PB0, and the finished packet is swapped into the
// active registers that feed the packet assembler.
// Optional build macro INFO_FRAME_SYNC_SWAP_EN: when defined, the active
// registers update only on a frame-boundary swap strobe; otherwise they
// update as soon as the checksum is ready.
module info_frame_engine #(
  parameter int   MAX_LENGTH  = 27,
  parameter logic HEADER_BIT7 = 1'b1
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [6:0]  hdr_type,
  input  logic [7:0]  hdr_version,
  input  logic [4:0]  hdr_length,
  input  logic        commit,
  input  logic        swap,
  output logic        busy,
  output logic        valid,
  output logic [23:0] header,
  output logic [55:0] sub [4]
);

  typedef enum logic [1:0] {IDLE, SUM, WAIT_SWAP} state_t;

  localparam logic [4:0] MAX_LEN = 5'(MAX_LENGTH);

  state_t      state_q, state_d;
  logic [7:0]  stage_q [1:27];
  logic [7:0]  stage_d [1:27];
  logic [6:0]  type_q, type_d;
  logic [7:0]  version_q, version_d;
  logic [4:0]  len_q, len_d;
  logic [7:0]  acc_q, acc_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  pb0_q, pb0_d;
  logic [23:0] header_q, header_d;
  logic [7:0]  act_q [0:27];
  logic [7:0]  act_d [0:27];
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic [7:0]  hdr_b0;
  logic [7:0]  sum_byte;
  logic [7:0]  acc_next;
  logic        load;

`ifndef INFO_FRAME_SYNC_SWAP_EN
  logic unused_swap;
  assign unused_swap = swap;
`endif

  // Next-state logic: staging writes, commit capture, checksum walk and packet load
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    type_d    = type_q;
    version_d = version_q;
    len_d     = len_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    pb0_d     = pb0_q;
    header_d  = header_q;
    act_d     = act_q;
    valid_d   = valid_q;
    load      = 1'b0;

    hdr_b0 = {HEADER_BIT7, type_q};

    // Byte fed to the accumulator: three header bytes, then PB1..PB(len)
    sum_byte = 8'h00;
    case (idx_q)
      5'd0:    sum_byte = hdr_b0;
      5'd1:    sum_byte = version_q;
      5'd2:    sum_byte = {3'b000, len_q};
      default: begin
        for (int i = 1; i <= 27; i++) begin
          if (idx_q == 5'(i + 2)) sum_byte = stage_q[i];
        end
      end
    endcase
    acc_next = acc_q + sum_byte;

    case (state_q)
      IDLE: begin
        if (wr_en && (wr_addr != 5'd0) && (wr_addr <= MAX_LEN)) begin
          for (int i = 1; i <= 27; i++) begin
            if (wr_addr == 5'(i)) stage_d[i] = wr_data;
          end
        end
        if (commit) begin
          type_d    = hdr_type;
          version_d = hdr_version;
          len_d     = (hdr_length > MAX_LEN) ? MAX_LEN : hdr_length;
          acc_d     = 8'h00;
          idx_d     = 5'd0;
          state_d   = SUM;
        end
      end
      SUM: begin
        acc_d = acc_next;
        idx_d = idx_q + 5'd1;
        if (idx_q == len_q + 5'd2) begin
          pb0_d   = (~acc_next) + 8'd1;
          state_d = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
`ifdef INFO_FRAME_SYNC_SWAP_EN
        load = swap;
`else
        load = 1'b1;
`endif
        if (load) begin
          header_d = {3'b000, len_q, version_q, hdr_b0};
          act_d[0] = pb0_q;
          for (int i = 1; i <= 27; i++) begin
            act_d[i] = (5'(i) <= len_q) ? stage_q[i] : 8'h00;
          end
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset that drops any pending packet
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q   <= IDLE;
      type_q    <= '0;
      version_q <= '0;
      len_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      pb0_q     <= '0;
      header_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 1; i <= 27; i++) stage_q[i] <= 8'h00;
      for (int i = 0; i <= 27; i++) act_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      type_q    <= type_d;
      version_q <= version_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      pb0_q     <= pb0_d;
      header_q  <= header_d;
      act_q     <= act_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign header = header_q;

  // Pack active bytes into subpackets, PB(7i) in the low byte of sub[i]
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 7; b++) begin
        sub[s][8*b +: 8] = act_q[7*s + b];
      end
    end
  end

endmodule

// File: tb/tb_info_frame_engine.sv
// tb_info_frame_engine: self-checking bench for info_frame_engine.
// Expected packets are pushed to a scoreboard at commit and popped when
// the engine publishes the packet. Honours INFO_FRAME_SYNC_SWAP_EN.
module tb_info_frame_engine;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [6:0]  hdr_type = '0;
  logic [7:0]  hdr_version = '0;
  logic [4:0]  hdr_length = '0;
  logic        commit = 1'b0;
  logic        swap = 1'b0;
  logic        busy;
  logic        valid;
  logic [23:0] header;
  logic [55:0] sub [4];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [23:0]  hdr;
    logic [223:0] body;
  } pkt_t;

  pkt_t       sb_q [$];
  pkt_t       cur;
  pkt_t       exp;
  logic [7:0] model [1:27];
  bit         ok;

  info_frame_engine dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .hdr_type    (hdr_type),
    .hdr_version (hdr_version),
    .hdr_length  (hdr_length),
    .commit      (commit),
    .swap        (swap),
    .busy        (busy),
    .valid       (valid),
    .header      (header),
    .sub         (sub)
  );

  // Free-running pixel clock
  always #5 clk_pixel = ~clk_pixel;

  // Watchdog so the run always terminates
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [223:0] dut_body();
    return {sub[3], sub[2], sub[1], sub[0]};
  endfunction

  // Reference packet built from the bench's own copy of the staging buffer
  function automatic pkt_t make_expected(logic [6:0] t, logic [7:0] v, logic [4:0] l);
    pkt_t p;
    logic [4:0] len;
    logic [7:0] b0;
    logic [7:0] sum;
    len = (l > 5'd27) ? 5'd27 : l;
    b0  = {1'b1, t};
    sum = b0 + v + {3'b000, len};
    p.body = '0;
    for (int i = 1; i <= 27; i++) begin
      if (i <= int'(len)) begin
        p.body[8*i +: 8] = model[i];
        sum = sum + model[i];
      end
    end
    p.body[7:0] = 8'h00 - sum;
    p.hdr = {3'b000, len, v, b0};
    return p;
  endfunction

  task automatic write_byte(input logic [4:0] addr, input logic [7:0] data);
    @(negedge clk_pixel);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk_pixel);
    wr_en = 1'b0;
    if (addr >= 5'd1 && addr <= 5'd27) model[addr] = data;
  endtask

  // Returns at the negedge of cycle T+1 where T is the commit cycle
  task automatic start_commit(input logic [6:0] t, input logic [7:0] v, input logic [4:0] l);
    @(negedge clk_pixel);
    commit = 1'b1; hdr_type = t; hdr_version = v; hdr_length = l;
    sb_q.push_back(make_expected(t, v, l));
    @(negedge clk_pixel);
    commit = 1'b0;
  endtask

  // Waits (bounded) until the committed packet is published
  task automatic wait_done(output bit done);
`ifdef INFO_FRAME_SYNC_SWAP_EN
    repeat (35) @(negedge clk_pixel);
    swap = 1'b1;
    @(negedge clk_pixel);
    swap = 1'b0;
    done = !busy;
`else
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk_pixel);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_pixel);
    reset = 1'b0;
    @(negedge clk_pixel);
    for (int i = 1; i <= 27; i++) model[i] = 8'h00;
    cur = '0;
    checks++; if (header !== 24'h000000) begin errors++; $display("[TB] FAIL reset_header got %h want %h", header, 24'h0); end
    checks++; if (dut_body() !== 224'h0) begin errors++; $display("[TB] FAIL reset_sub got %h want 0", dut_body()); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_avi();
    write_byte(5'd4, 8'h04);
    start_commit(7'd2, 8'd2, 5'd13);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL avi_busy got %b want 1", busy); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL avi_timeout got busy want idle"); end
    exp = sb_q.pop_front();
    checks++; if (header !== exp.hdr) begin errors++; $display("[TB] FAIL avi_header got %h want %h", header, exp.hdr); end
    checks++; if (dut_body() !== exp.body) begin errors++; $display("[TB] FAIL avi_body got %h want %h", dut_body(), exp.body); end
    checks++; if (header !== 24'h0D0282) begin errors++; $display("[TB] FAIL avi_header_const got %h want 0d0282", header); end
    checks++; if (sub[0] !== 56'h0000040000006B) begin errors++; $display("[TB] FAIL avi_sub0 got %h want 0000040000006b", sub[0]); end
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL avi_valid got %b want 1", valid); end
    cur = exp;
  endtask

  task automatic test_latency();
    // A swap in IDLE must not disturb anything
    @(negedge clk_pixel);
    swap = 1'b1;
    @(negedge clk_pixel);
    swap = 1'b0;
    checks++; if (header !== cur.hdr || dut_body() !== cur.body || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_swap got %h/%b want %h/0", header, busy, cur.hdr);
    end
    write_byte(5'd2, 8'h55);
    start_commit(7'd2, 8'd2, 5'd13);
    exp = sb_q.pop_front();
`ifdef INFO_FRAME_SYNC_SWAP_EN
    for (int k = 1; k <= 21; k++) begin
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL lat_busy_rise got %b want 1", busy); end
      end
      if (k == 20) begin
        checks++; if (header !== cur.hdr || dut_body() !== cur.body || busy !== 1'b1) begin
          errors++; $display("[TB] FAIL lat_hold got %h busy %b want %h busy 1", dut_body(), busy, cur.body);
        end
        swap = 1'b1;
      end
      if (k == 21) begin
        swap = 1'b0;
        checks++; if (header !== exp.hdr || dut_body() !== exp.body) begin
          errors++; $display("[TB] FAIL lat_update got %h want %h", dut_body(), exp.body);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL lat_busy_fall got %b want 0", busy); end
      end
      if (k < 21) @(negedge clk_pixel);
    end
`else
    for (int k = 1; k <= 18; k++) begin
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL lat_busy_rise got %b want 1", busy); end
      end
      if (k == 17) begin
        checks++; if (header !== cur.hdr || dut_body() !== cur.body || busy !== 1'b1) begin
          errors++; $display("[TB] FAIL lat_hold got %h busy %b want %h busy 1", dut_body(), busy, cur.body);
        end
      end
      if (k == 18) begin
        checks++; if (header !== exp.hdr || dut_body() !== exp.body) begin
          errors++; $display("[TB] FAIL lat_update got %h want %h", dut_body(), exp.body);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL lat_busy_fall got %b want 0", busy); end
      end
      if (k < 18) @(negedge clk_pixel);
    end
`endif
    cur = exp;
  endtask

  task automatic test_clamp();
    write_byte(5'd20, 8'hAA);
    start_commit(7'd3, 8'd1, 5'd31);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL clamp_timeout got busy want idle"); end
    exp = sb_q.pop_front();
    checks++; if (header !== exp.hdr || dut_body() !== exp.body) begin
      errors++; $display("[TB] FAIL clamp_packet got %h %h want %h %h", header, dut_body(), exp.hdr, exp.body);
    end
    checks++; if (header[23:16] !== 8'd27) begin errors++; $display("[TB] FAIL clamp_len got %0d want 27", header[23:16]); end
    checks++; if (sub[2][55:48] !== 8'hAA) begin errors++; $display("[TB] FAIL clamp_pb20 got %h want aa", sub[2][55:48]); end
    cur = exp;
    start_commit(7'd3, 8'd1, 5'd5);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL short_timeout got busy want idle"); end
    exp = sb_q.pop_front();
    checks++; if (header !== exp.hdr || dut_body() !== exp.body) begin
      errors++; $display("[TB] FAIL short_packet got %h %h want %h %h", header, dut_body(), exp.hdr, exp.body);
    end
    checks++; if (sub[2][55:48] !== 8'h00) begin errors++; $display("[TB] FAIL short_pb20 got %h want 00", sub[2][55:48]); end
    cur = exp;
  endtask

  task automatic test_busy_reset();
    write_byte(5'd1, 8'h11);
    start_commit(7'd4, 8'd1, 5'd3);
    @(negedge clk_pixel);
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'hEE;
    commit = 1'b1; hdr_type = 7'd5; hdr_version = 8'd9; hdr_length = 5'd10;
    @(negedge clk_pixel);
    wr_en = 1'b0; commit = 1'b0;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL busy_timeout got busy want idle"); end
    exp = sb_q.pop_front();
    checks++; if (header !== exp.hdr || dut_body() !== exp.body) begin
      errors++; $display("[TB] FAIL busy_packet got %h %h want %h %h", header, dut_body(), exp.hdr, exp.body);
    end
    checks++; if (sub[0][15:8] !== 8'h11) begin errors++; $display("[TB] FAIL busy_pb1 got %h want 11", sub[0][15:8]); end
    @(negedge clk_pixel);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_ignored_commit got %b want 0", busy); end
    // Reset while waiting for the swap discards the pending packet
    start_commit(7'd4, 8'd1, 5'd3);
    repeat (6) @(negedge clk_pixel);
    reset = 1'b1;
    @(negedge clk_pixel);
    reset = 1'b0;
    sb_q.delete();
    for (int i = 1; i <= 27; i++) model[i] = 8'h00;
    checks++; if (valid !== 1'b0 || header !== 24'h0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midop_reset got v%b h%h b%b want v0 h000000 b0", valid, header, busy);
    end
    @(negedge clk_pixel);
    swap = 1'b1;
    @(negedge clk_pixel);
    swap = 1'b0;
    @(negedge clk_pixel);
    checks++; if (valid !== 1'b0 || header !== 24'h0 || dut_body() !== 224'h0) begin
      errors++; $display("[TB] FAIL post_reset_swap got v%b h%h want v0 h000000", valid, header);
    end
  endtask

  // Test sequence
  initial begin
    $display("[TB] start");
    test_reset();
    test_avi();
    test_latency();
    test_clamp();
    test_busy_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
